// File: rtl/nine_to_one_collect_module.sv
// Nine-lane parallel-to-serial collector.
// It captures nine lane words on an accepted start and emits the enabled lanes
// one per handshake, in ascending lane order, each tagged with its lane code.
module nine_to_one_collect_module #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [8:0]       lane_en,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LANES = 9;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [WIDTH-1:0]  data_q [LANES];
  logic [LANES-1:0]  mask_q;
  logic [SEL_W-1:0]  idx;

  logic [WIDTH-1:0]  lane_in [LANES];
  logic [SEL_W-1:0]  first_idx;
  logic              first_found;
  logic [SEL_W-1:0]  next_idx;
  logic              next_found;
  logic              handshake;

  assign lane_in[0] = in1;
  assign lane_in[1] = in2;
  assign lane_in[2] = in3;
  assign lane_in[3] = in4;
  assign lane_in[4] = in5;
  assign lane_in[5] = in6;
  assign lane_in[6] = in7;
  assign lane_in[7] = in8;
  assign lane_in[8] = in9;

  assign handshake = out_valid & out_ready;

  // Lowest enabled lane of the incoming mask (downward scan leaves the lowest hit).
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_en[i]) begin
        first_idx   = SEL_W'(i);
        first_found = 1'b1;
      end
    end
  end

  // Lowest captured lane strictly above the current one.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_q[i] && (SEL_W'(i) > idx)) begin
        next_idx   = SEL_W'(i);
        next_found = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs; the next word is preloaded on each handshake
  // so enabled lanes stream with no bubbles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      mask_q    <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < LANES; i++) data_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < LANES; i++) data_q[i] <= lane_in[i];
            mask_q <= lane_en;
            if (first_found) begin
              idx       <= first_idx;
              out_data  <= lane_in[first_idx];
              out_sel   <= first_idx;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= SEND;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            if (next_found) begin
              idx      <= next_idx;
              out_data <= data_q[next_idx];
              out_sel  <= next_idx;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nine_to_one_collect_module.sv
// Directed bench for the nine-lane collector.
// Inputs are driven and outputs sampled on the falling edge; one task per scenario.
module tb_nine_to_one_collect_module;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in1, in2, in3, in4, in5, in6, in7, in8, in9;
  logic [8:0] lane_en;
  logic       start;
  logic [7:0] out_data;
  logic [3:0] out_sel;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Observed word: {valid, busy, done, sel, data}
  logic [14:0] obs;
  logic [14:0] exp_w;

  assign obs = {out_valid, busy, done, out_sel, out_data};

  always #5 clk = ~clk;

  nine_to_one_collect_module #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .in6(in6), .in7(in7), .in8(in8), .in9(in9),
    .lane_en(lane_en), .start(start),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic set_lanes(input logic [7:0] base);
    in1 = base + 8'd1; in2 = base + 8'd2; in3 = base + 8'd3;
    in4 = base + 8'd4; in5 = base + 8'd5; in6 = base + 8'd6;
    in7 = base + 8'd7; in8 = base + 8'd8; in9 = base + 8'd9;
  endtask

  // Emitting word for lane code s of a frame with the given base.
  function automatic logic [14:0] word(input logic [7:0] base, input int s);
    logic [3:0] sel;
    sel = 4'(s);
    return {1'b1, 1'b1, 1'b0, sel, 8'(base + 8'(s) + 8'd1)};
  endfunction

  // Frame-complete cycle: done pulse, not valid, not busy; data holds the last word.
  function automatic logic [14:0] fin(input logic [7:0] base, input int s);
    logic [3:0] sel;
    sel = 4'(s);
    return {1'b0, 1'b0, 1'b1, sel, 8'(base + 8'(s) + 8'd1)};
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b1; lane_en = '0; set_lanes(8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 15'h0) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs, 15'h0);
    end
  endtask

  task automatic test_full_frame;
    set_lanes(8'h10); lane_en = 9'h1FF; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_w = word(8'h10, i);
      checks++;
      if (obs !== exp_w) begin
        errors++; $display("FAIL full_word%0d got=%h want=%h", i, obs, exp_w);
      end
      @(negedge clk);
    end
    exp_w = fin(8'h10, 8);
    checks++;
    if (obs !== exp_w) begin
      errors++; $display("FAIL full_done got=%h want=%h", obs, exp_w);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL full_idle got=%b want=000", {out_valid, busy, done});
    end
  endtask

  task automatic test_sparse;
    int sels [3];
    sels = '{0, 4, 8};
    set_lanes(8'h20); lane_en = 9'b100010001; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_w = word(8'h20, sels[i]);
      checks++;
      if (obs !== exp_w) begin
        errors++; $display("FAIL sparse_word%0d got=%h want=%h", i, obs, exp_w);
      end
      @(negedge clk);
    end
    exp_w = fin(8'h20, 8);
    checks++;
    if (obs !== exp_w) begin
      errors++; $display("FAIL sparse_done got=%h want=%h", obs, exp_w);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k = 0;
    int stalls = 0;
    int hold = 0;
    bit seen_done = 1'b0;
    set_lanes(8'h30); lane_en = 9'h1FF; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (out_valid) begin
        exp_w = word(8'h30, k);
        checks++;
        if (obs !== exp_w) begin
          errors++; $display("FAIL bp_word%0d got=%h want=%h", k, obs, exp_w);
        end
        if (out_sel == 4'd3) hold++;
        if (out_sel == 4'd3 && stalls < 3) begin
          out_ready = 1'b0; stalls++;
        end else begin
          out_ready = 1'b1; k++;
        end
      end
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (k !== 9 || hold !== 4 || !seen_done) begin
      errors++;
      $display("FAIL bp_totals words=%0d hold=%0d done=%0d want words=9 hold=4 done=1", k, hold, seen_done);
    end
  endtask

  task automatic test_empty_and_ignored_start;
    set_lanes(8'h00); lane_en = 9'h000; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({out_valid, busy, done} !== 3'b001) begin
      errors++; $display("FAIL empty_done got=%b want=001", {out_valid, busy, done});
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL empty_after got=%b want=000", {out_valid, busy, done});
    end
    set_lanes(8'h40); lane_en = 9'h1FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin
        set_lanes(8'h50); lane_en = 9'h001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      exp_w = word(8'h40, i);
      checks++;
      if (obs !== exp_w) begin
        errors++; $display("FAIL ignore_word%0d got=%h want=%h", i, obs, exp_w);
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_w = fin(8'h40, 8);
    checks++;
    if (obs !== exp_w) begin
      errors++; $display("FAIL ignore_done got=%h want=%h", obs, exp_w);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    set_lanes(8'h60); lane_en = 9'b000000011; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_w = word(8'h60, i);
      checks++;
      if (obs !== exp_w) begin
        errors++; $display("FAIL b2b_a_word%0d got=%h want=%h", i, obs, exp_w);
      end
      @(negedge clk);
    end
    exp_w = fin(8'h60, 1);
    checks++;
    if (obs !== exp_w) begin
      errors++; $display("FAIL b2b_a_done got=%h want=%h", obs, exp_w);
    end
    set_lanes(8'h70); lane_en = 9'b110000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 7; i < 9; i++) begin
      exp_w = word(8'h70, i);
      checks++;
      if (obs !== exp_w) begin
        errors++; $display("FAIL b2b_b_word%0d got=%h want=%h", i, obs, exp_w);
      end
      @(negedge clk);
    end
    exp_w = fin(8'h70, 8);
    checks++;
    if (obs !== exp_w) begin
      errors++; $display("FAIL b2b_b_done got=%h want=%h", obs, exp_w);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    set_lanes(8'h80); lane_en = 9'h1FF; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    exp_w = word(8'h80, 3);
    checks++;
    if (obs !== exp_w) begin
      errors++; $display("FAIL rst_pre got=%h want=%h", obs, exp_w);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (obs !== 15'h0) begin
      errors++; $display("FAIL rst_mid got=%h want=%h", obs, 15'h0);
    end
    @(negedge clk);
    checks++;
    if (obs !== 15'h0) begin
      errors++; $display("FAIL rst_no_done got=%h want=%h", obs, 15'h0);
    end
    set_lanes(8'h90); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_w = word(8'h90, i);
      checks++;
      if (obs !== exp_w) begin
        errors++; $display("FAIL rst_fresh_word%0d got=%h want=%h", i, obs, exp_w);
      end
      @(negedge clk);
    end
    exp_w = fin(8'h90, 8);
    checks++;
    if (obs !== exp_w) begin
      errors++; $display("FAIL rst_fresh_done got=%h want=%h", obs, exp_w);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sparse();
    test_backpressure();
    test_empty_and_ignored_start();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
